// File: rtl/flopr_trace_if.sv
// Tuple read port of the flopr trace recorder.
// master drives the tuple and valid; slave drives ready.
interface flopr_trace_if #(
   parameter int N = 64
);
   logic         rd_valid;
   logic         rd_ready;
   logic         rd_reset;
   logic [N-1:0] rd_d;
   logic [N-1:0] rd_q;

   modport master (
      output rd_valid,
      output rd_reset,
      output rd_d,
      output rd_q,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_reset,
      input  rd_d,
      input  rd_q,
      output rd_ready
   );
endinterface

// File: rtl/flopr_trace.sv
// Trace recorder for a resettable register: captures {reset,d,q}
// once per clock while armed, then drains the tuples in order.
module flopr_trace #(
   parameter  int N     = 64,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          arm,
   input  logic          stop,
   input  logic          obs_reset,
   input  logic [N-1:0]  obs_d,
   input  logic [N-1:0]  obs_q,
   flopr_trace_if.master rd,
   output logic          busy,
   output logic [CW-1:0] count
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } state_t;

   typedef struct packed {
      logic         rst;
      logic [N-1:0] d;
      logic [N-1:0] q;
   } tuple_t;

   state_t  state, state_nxt;
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   tuple_t  mem [DEPTH];
   tuple_t  head;
   logic    xfer;

   assign xfer = (state == DRAIN) && rd.rd_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (arm) state_nxt = CAPTURE;
         CAPTURE:
            if (stop || cnt == CW'(DEPTH - 1))
               state_nxt = DRAIN;
         DRAIN:
            if (xfer && cnt == CW'(1))
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               wp  <= '0;
               rp  <= '0;
               cnt <= '0;
            end
            CAPTURE: begin
               wp  <= wp + AW'(1);
               cnt <= cnt + CW'(1);
            end
            DRAIN:
               if (xfer) begin
                  cnt <= cnt - CW'(1);
                  rp  <= (cnt == CW'(1)) ? '0 : rp + AW'(1);
                  if (cnt == CW'(1)) wp <= '0;
               end
            default: ;
         endcase
      end
   end

   // buffer needs no reset; it is only read behind valid counts
   always_ff @(posedge clk) begin
      if (state == CAPTURE)
         mem[wp] <= '{rst: obs_reset, d: obs_d, q: obs_q};
   end

   always_comb begin
      head        = '0;
      rd.rd_valid = 1'b0;
      if (state == DRAIN) begin
         head        = mem[rp];
         rd.rd_valid = 1'b1;
      end
      rd.rd_reset = head.rst;
      rd.rd_d     = head.d;
      rd.rd_q     = head.q;
   end

   assign busy  = (state != IDLE);
   assign count = cnt;

endmodule

// File: tb/tb_flopr_trace.sv
// Scoreboard bench for flopr_trace: directed capture/drain
// scenarios with a monitor popping expected tuples.
module tb_flopr_trace;

   localparam int N  = 64;
   localparam int D  = 16;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          arm, stop;
   logic          obs_reset;
   logic [N-1:0]  obs_d, obs_q;
   logic          busy;
   logic [CW-1:0] count;

   flopr_trace_if #(.N(N)) rd_if ();

   flopr_trace #(.N(N), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .arm       (arm),
      .stop      (stop),
      .obs_reset (obs_reset),
      .obs_d     (obs_d),
      .obs_q     (obs_q),
      .rd        (rd_if.master),
      .busy      (busy),
      .count     (count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [2*N:0] sb[$];

   task automatic chk(input string name,
                      input logic [2*N:0] act,
                      input logic [2*N:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // monitor: every accepted tuple must match the scoreboard head
   always @(negedge clk) begin
      if (rd_if.rd_valid === 1'b1 && rd_if.rd_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL tuple: got %h want none",
                     {rd_if.rd_reset, rd_if.rd_d, rd_if.rd_q});
         end else begin
            chk("tuple", {rd_if.rd_reset, rd_if.rd_d, rd_if.rd_q},
                sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("busy_arm", 129'(busy), 129'(1));
   endtask

   task automatic cap(input logic r, input logic [N-1:0] d,
                      input logic [N-1:0] q, input logic s);
      obs_reset = r;
      obs_d     = d;
      obs_q     = q;
      stop      = s;
      sb.push_back({r, d, q});
      step();
      stop = 1'b0;
   endtask

   task automatic drain_all(input string name);
      int b;
      b = 0;
      rd_if.rd_ready = 1'b1;
      while (busy && b < 40) begin
         step();
         b++;
      end
      rd_if.rd_ready = 1'b0;
      chk({name, "_idle"}, 129'(busy), 129'(0));
      chk({name, "_sb"}, 129'(sb.size()), 129'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [CW-1:0] c0;
      logic [N-1:0]  d0;
      logic          rdy;
      int            p;

      reset = 1'b0;
      arm = 1'b0;
      stop = 1'b0;
      obs_reset = 1'b0;
      obs_d = '0;
      obs_q = '0;
      rd_if.rd_ready = 1'b0;
      #12;
      chk("rst_busy", 129'(busy), 129'(0));
      chk("rst_valid", 129'(rd_if.rd_valid), 129'(0));
      chk("rst_count", 129'(count), 129'(0));
      chk("rst_d", 129'(rd_if.rd_d), 129'(0));
      reset = 1'b1;
      step();

      // full capture of 16 tuples
      do_arm();
      cap(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      for (int i = 1; i < D; i++)
         cap(1'b0, 64'(i), 64'(i - 1), 1'b0);
      chk("full_count", 129'(count), 129'(16));
      chk("full_valid", 129'(rd_if.rd_valid), 129'(1));
      chk("full_t0", {rd_if.rd_reset, rd_if.rd_d, rd_if.rd_q},
          {1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      rd_if.rd_ready = 1'b1;
      for (int j = 0; j < D; j++) begin
         chk("full_cnt_dn", 129'(count), 129'(16 - j));
         step();
      end
      rd_if.rd_ready = 1'b0;
      chk("full_done_busy", 129'(busy), 129'(0));
      chk("full_done_valid", 129'(rd_if.rd_valid), 129'(0));
      chk("full_done_d", 129'(rd_if.rd_d), 129'(0));

      // early stop after three tuples
      do_arm();
      cap(1'b0, 64'hA, 64'h1, 1'b0);
      cap(1'b0, 64'hB, 64'hA, 1'b0);
      cap(1'b0, 64'hC, 64'hB, 1'b1);
      chk("stop_count", 129'(count), 129'(3));
      drain_all("stop");

      // backpressure: ready 1,0,0,1,0,0,...
      do_arm();
      for (int i = 0; i < 4; i++)
         cap(1'b0, 64'h100 + 64'(i), 64'h200 + 64'(i), i == 3);
      p = 0;
      while (busy && p < 30) begin
         rdy = (p % 3 == 0);
         rd_if.rd_ready = rdy;
         c0 = count;
         d0 = rd_if.rd_d;
         step();
         chk("bp_count", 129'(count),
             129'(rdy ? c0 - CW'(1) : c0));
         if (!rdy) chk("bp_hold", 129'(rd_if.rd_d), 129'(d0));
         p++;
      end
      rd_if.rd_ready = 1'b0;
      chk("bp_idle", 129'(busy), 129'(0));
      chk("bp_sb", 129'(sb.size()), 129'(0));

      // ignored controls
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("ign_stop_idle", 129'(busy), 129'(0));
      do_arm();
      cap(1'b0, 64'h51, 64'h50, 1'b0);
      arm = 1'b1;
      cap(1'b1, 64'h52, 64'h51, 1'b0);
      arm = 1'b0;
      cap(1'b0, 64'h53, 64'h52, 1'b1);
      chk("ign_arm_cap", 129'(count), 129'(3));
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("ign_arm_drain", 129'(count), 129'(3));
      chk("ign_drain_d", 129'(rd_if.rd_d), 129'(64'h51));
      drain_all("ign");

      // asynchronous reset mid-capture
      do_arm();
      for (int i = 0; i < 5; i++)
         cap(1'b0, 64'hE0 + 64'(i), 64'h0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_busy", 129'(busy), 129'(0));
      chk("ar_valid", 129'(rd_if.rd_valid), 129'(0));
      chk("ar_count", 129'(count), 129'(0));
      sb.delete();
      #2;
      reset = 1'b1;
      step();
      chk("ar_idle", 129'(busy), 129'(0));
      do_arm();
      cap(1'b1, 64'h77, 64'h66, 1'b0);
      cap(1'b0, 64'h88, 64'h77, 1'b1);
      chk("ar_count2", 129'(count), 129'(2));
      chk("ar_first", 129'(rd_if.rd_d), 129'(64'h77));
      drain_all("ar");

      // stop on the 16th capture cycle
      do_arm();
      for (int i = 0; i < D; i++)
         cap(1'b0, 64'hF00 + 64'(i), 64'(i), i == D - 1);
      chk("sf_count", 129'(count), 129'(16));
      step();
      chk("sf_hold", 129'(count), 129'(16));
      chk("sf_entry0", 129'(rd_if.rd_d), 129'(64'hF00));
      drain_all("sf");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/flopr_trace.md
# flopr_trace

Hardware trace recorder for N-bit resettable registers in the single-cycle datapath. While armed it captures one `{reset, d, q}` tuple per clock into an internal buffer, the same tuple format our register test vectors use. It then drains the tuples in order over a valid/ready port, so the tuples can be written out as vector lines or compared on-chip. It sits beside any `flopr` instance and passively observes its inputs and output.

## Interface
- `N`, 64, width of observed `d`/`q`
- `DEPTH`, 16, tuple capacity; power of two, ≥ 2
- `clk`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `arm`  in  1  start capture (honoured only in IDLE)
- `stop`  in  1  end capture early (honoured only in CAPTURE)
- `obs_reset`  in  1  observed register's reset
- `obs_d`  in  N  observed register's `d`
- `obs_q`  in  N  observed register's `q`
- `rd_ready`  in  1  consumer accepts tuple
- `rd_valid`  out  1  tuple available
- `rd_reset`  out  1  tuple field
- `rd_d`  out  N  tuple field
- `rd_q`  out  N  tuple field
- `busy`  out  1  state ≠ IDLE
- `count`  out  $clog2(DEPTH)+1  tuples currently held

## Operation
- Storage: DEPTH entries of 2N+1 bits; write pointer `wp` and read pointer `rp` are $clog2(DEPTH) bits; `count` is tracked separately, range 0..DEPTH.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE → CAPTURE when `arm`=1. On entry, `wp`=`rp`=`count`=0. In IDLE, `stop` and `rd_ready` are ignored.
- CAPTURE, every rising edge:
  - write `{obs_reset, obs_d, obs_q}` to entry `wp`;
  - `wp`++, `count`++.
  - Go to DRAIN if `stop`=1 (the current tuple is included) or if this write makes `count`=DEPTH. Both conditions in the same cycle give one transition and one write.
  - `arm` is ignored.
- DRAIN:
  - `rd_valid`=1; `rd_*` = entry `rp`.
  - Transfer occurs when `rd_valid`&`rd_ready`: `rp`++, `count`--.
  - Transfer of the last tuple (`count`=1) → IDLE, with `rp`, `wp` cleared.
  - `arm` is ignored.
  - `obs_*` are not sampled.
- While `rd_valid`=0, `rd_reset`/`rd_d`/`rd_q` are 0.
- While `rd_valid`=1 and `rd_ready`=0, `rd_*` hold stable.
- Tuple order out equals capture order; no drops, no duplicates.
- DRAIN always holds ≥1 tuple, so an empty DRAIN is unreachable.
- Pointer wrap: `wp` reaching DEPTH-1 then writing sets `count`=DEPTH and forces DRAIN, so there is never an overwrite.

## Timing
- Reset asserted (0): asynchronously forces state=IDLE, `wp`=`rp`=`count`=0, `rd_valid`=0, `busy`=0, `rd_*`=0. Buffer contents need no clearing.
- Reset mid-CAPTURE or mid-DRAIN: pending tuples are discarded. The first edge after release sees IDLE.
- `arm` high at edge k: `busy`=1 after edge k. The first tuple is the one present on `obs_*` in cycle k+1, written at edge k+1.
- Capture rate: 1 tuple/cycle.
- A full capture ends at edge k+DEPTH. `rd_valid`=1 from that edge onward, so the first tuple is readable in the very next cycle.
- Drain throughput: 1 tuple/cycle with `rd_ready` held high.
- `rd_*` are a combinational read of the register array at `rp`; no read latency.
- After the last transfer edge: `rd_valid`=0 and `busy`=0. `arm` is honoured on the next edge.
- Minimum cycle for a 1-tuple trace:
  - `arm` edge;
  - capture edge with `stop`=1;
  - transfer edge;
  - total of 3 edges back to IDLE.

## Test plan
- Full capture, N=64, DEPTH=16: arm, then drive `obs_d`=i, `obs_q`=i-1, `obs_reset`=(i==0) for i=0..15; `rd_ready`=1 → 16 tuples out in order, tuple 0 = {1,0,0xFFFF_FFFF_FFFF_FFFF}, tuple 15 = {0,15,14}; `count` goes 16→0; `busy` falls after 16th transfer.
- Early stop: arm, capture 3 cycles with `obs_d`=0xA,0xB,0xC, `stop`=1 in the third → `count`=3, drain yields exactly 0xA,0xB,0xC, then IDLE.
- Backpressure: in DRAIN toggle `rd_ready` 1,0,0,1,… → `rd_*` hold constant while `rd_ready`=0; no tuple skipped or repeated; `count` decrements only on ready cycles.
- Ignored controls: pulse `arm` during CAPTURE and DRAIN, and `stop` in IDLE → no state change, no pointer reset; the trace is unchanged.
- Reset mid-operation: assert `reset`=0 asynchronously (between edges) after 5 captured tuples → `busy`, `rd_valid`, `count` drop to 0 immediately; after release, a new arm captures from entry 0.
- Stop coinciding with full: `stop`=1 on the 16th capture cycle → exactly 16 tuples, a single DRAIN entry, no overwrite of entry 0.
